// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32 control sequencer.
package ctrl_pkg;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StHalt   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        ClsR,
        ClsI,
        ClsLoad,
        ClsStore,
        ClsBranch,
        ClsJal,
        ClsIllegal
    } instr_class_t;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] PC_SEL_PC4    = 2'b00;
    localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
    localparam logic [1:0] PC_SEL_JAL    = 2'b10;

    localparam logic [1:0] WB_SEL_ALU = 2'b00;
    localparam logic [1:0] WB_SEL_MEM = 2'b01;
    localparam logic [1:0] WB_SEL_PC4 = 2'b10;

    localparam logic [1:0] ALU_B_RS2 = 2'b00;
    localparam logic [1:0] ALU_B_IMM = 2'b01;

    function automatic instr_class_t decode_class(input logic [6:0] opcode);
        case (opcode)
            OPC_R:      return ClsR;
            OPC_I:      return ClsI;
            OPC_LOAD:   return ClsLoad;
            OPC_STORE:  return ClsStore;
            OPC_BRANCH: return ClsBranch;
            OPC_JAL:    return ClsJal;
            default:    return ClsIllegal;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation select from instruction class and function fields.
module alu_decoder
    import ctrl_pkg::*;
(
    input  instr_class_t cls,
    input  logic [2:0]   funct3,
    input  logic         funct7_5,
    output logic [3:0]   alu_ctrl
);

    // Branches compare by subtraction; ALU classes follow funct3; everything else adds.
    always_comb begin
        alu_ctrl = ALU_ADD;
        case (cls)
            ClsBranch: alu_ctrl = ALU_SUB;
            ClsR, ClsI: begin
                case (funct3)
                    3'b000:  alu_ctrl = (cls == ClsR && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b111:  alu_ctrl = ALU_AND;
                    3'b110:  alu_ctrl = ALU_OR;
                    3'b100:  alu_ctrl = ALU_XOR;
                    3'b010:  alu_ctrl = ALU_SLT;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32 sequencer: FETCH/DECODE/EXEC/MEM/WB with a shared memory port,
// ready handshake and a sticky timeout. MAX_WAIT must be >= 1 and < 2**WAIT_W.
// Optional macro ILLEGAL_TRAP_EN adds a trap output; illegal opcodes then halt.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned WAIT_W   = 8,
    parameter int unsigned MAX_WAIT = 200
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        alu_zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_is_fetch,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [3:0]  alu_ctrl,
    output logic        reg_wr_en,
    output logic [1:0]  wb_sel,
    output logic [2:0]  state_o,
`ifdef ILLEGAL_TRAP_EN
    output logic        trap,
`endif
    output logic        bus_err
);

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                bus_err_q, bus_err_d;

    instr_class_t cls;
    logic [3:0]   dec_alu_ctrl;
    logic         rd_nz;
    logic         taken;
    logic         mem_busy;
    logic         wait_hit;
    logic         unused_instr;

    assign cls      = decode_class(instr[6:0]);
    assign rd_nz    = |instr[11:7];
    assign taken    = alu_zero ^ instr[12];
    assign mem_busy = (state_q == StFetch) || (state_q == StMem);
    // This cycle's miss would be the MAX_WAIT-th in a row; mem_ready this cycle wins.
    assign wait_hit = mem_busy && !mem_ready && (wait_cnt_q == WAIT_W'(MAX_WAIT - 1));
    assign unused_instr = ^{instr[31], instr[29:15]};

    alu_decoder u_alu_decoder (
        .cls      (cls),
        .funct3   (instr[14:12]),
        .funct7_5 (instr[30]),
        .alu_ctrl (dec_alu_ctrl)
    );

    // State, wait counter and sticky error register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StFetch;
            wait_cnt_q <= '0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            bus_err_q  <= bus_err_d;
        end
    end

    // Next state; the counter only survives consecutive un-acknowledged request cycles.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;
        bus_err_d  = bus_err_q;
        if (mem_busy && !mem_ready) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
        case (state_q)
            StFetch: begin
                if (mem_ready) begin
                    state_d = StDecode;
                end else if (wait_hit) begin
                    state_d   = StHalt;
                    bus_err_d = 1'b1;
                end
            end
            StDecode: begin
                if (cls == ClsIllegal) begin
`ifdef ILLEGAL_TRAP_EN
                    state_d = StHalt;
`else
                    state_d = StFetch;
`endif
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                case (cls)
                    ClsR, ClsI:        state_d = StWb;
                    ClsLoad, ClsStore: state_d = StMem;
                    default:           state_d = StFetch;
                endcase
            end
            StMem: begin
                if (mem_ready) begin
                    state_d = (cls == ClsStore) ? StFetch : StWb;
                end else if (wait_hit) begin
                    state_d   = StHalt;
                    bus_err_d = 1'b1;
                end
            end
            StWb:    state_d = StFetch;
            StHalt:  state_d = StHalt;
            default: state_d = StFetch;
        endcase
    end

    // Datapath controls; everything is held at zero while reset is asserted.
    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_is_fetch = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = PC_SEL_PC4;
        alu_src_a    = 1'b0;
        alu_src_b    = ALU_B_RS2;
        alu_ctrl     = 4'b0000;
        reg_wr_en    = 1'b0;
        wb_sel       = WB_SEL_ALU;
        state_o      = reset ? 3'd0 : state_q;
        bus_err      = bus_err_q && !reset;
`ifdef ILLEGAL_TRAP_EN
        trap         = 1'b0;
`endif
        if (!reset) begin
            case (state_q)
                StFetch: begin
                    mem_req      = 1'b1;
                    mem_is_fetch = 1'b1;
                    if (mem_ready) begin
                        ir_we  = 1'b1;
                        pc_we  = 1'b1;
                        pc_sel = PC_SEL_PC4;
                    end
                end
                StDecode: begin
`ifdef ILLEGAL_TRAP_EN
                    trap = (cls == ClsIllegal);
`endif
                end
                StExec: begin
                    case (cls)
                        ClsR: begin
                            alu_src_b = ALU_B_RS2;
                            alu_ctrl  = dec_alu_ctrl;
                        end
                        ClsI, ClsLoad, ClsStore: begin
                            alu_src_b = ALU_B_IMM;
                            alu_ctrl  = dec_alu_ctrl;
                        end
                        ClsBranch: begin
                            alu_src_b = ALU_B_RS2;
                            alu_ctrl  = dec_alu_ctrl;
                            if (taken) begin
                                pc_we  = 1'b1;
                                pc_sel = PC_SEL_BRANCH;
                            end
                        end
                        ClsJal: begin
                            reg_wr_en = rd_nz;
                            wb_sel    = WB_SEL_PC4;
                            pc_we     = 1'b1;
                            pc_sel    = PC_SEL_JAL;
                        end
                        default: ;
                    endcase
                end
                StMem: begin
                    // Keep the rs1+imm address computation alive for the whole request.
                    mem_req   = 1'b1;
                    mem_we    = (cls == ClsStore);
                    alu_src_b = ALU_B_IMM;
                    alu_ctrl  = ALU_ADD;
                end
                StWb: begin
                    reg_wr_en = rd_nz;
                    wb_sel    = (cls == ClsLoad) ? WB_SEL_MEM : WB_SEL_ALU;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the RV32 datapath (PC, IR, reg_file, ALU, one shared memory port).
- Walks each instruction through FETCH/DECODE/EXEC/MEM/WB and emits every datapath enable and mux select.
- Arbitrates the single memory port between instruction fetch and data access with a ready handshake, and watches that handshake for timeout.

Parameters:
- WAIT_W, 8: width of the memory-wait counter.
- MAX_WAIT, 200: consecutive un-acknowledged request cycles before bus error; must be < 2**WAIT_W.

Ports:
- clock, in, 1: single system clock, rising edge.
- reset, in, 1: synchronous, active-high reset.
- instr, in, 32: IR contents; valid from DECODE onward.
- alu_zero, in, 1: ALU result == 0.
- mem_ready, in, 1: memory accepts/completes the current request this cycle.
- mem_req, out, 1: memory request.
- mem_we, out, 1: store when 1, read when 0.
- mem_is_fetch, out, 1: address mux; 1 = PC, 0 = ALU result.
- ir_we, out, 1: IR load, and the datapath captures old_pc.
- pc_we, out, 1: PC write.
- pc_sel, out, 2: PC source; 00 = PC+4, 01 = old_pc+imm_b, 10 = old_pc+imm_j.
- alu_src_a, out, 1: ALU A source; 0 = rs1, 1 = old_pc.
- alu_src_b, out, 2: ALU B source; 00 = rs2, 01 = imm.
- alu_ctrl, out, 4: 0010 add, 0110 sub, 0000 and, 0001 or, 0011 xor, 0111 slt.
- reg_wr_en, out, 1: register file write.
- wb_sel, out, 2: writeback source; 00 = ALU, 01 = mem read data, 10 = PC+4.
- state_o, out, 3: current state encoding, for debug.
- bus_err, out, 1: sticky memory-timeout flag.

Behaviour:
- Reset
  - Synchronous, active-high: state=FETCH, wait_cnt=0, bus_err=0.
  - While reset=1 all outputs are forced to 0.
  - Reset mid-MEM or mid-FETCH abandons the request; mem_req is 0 in the reset cycle.
- Outputs
  - Combinational from state, instr fields and mem_ready.
  - Any output not listed for a state is 0.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- FETCH
  - mem_req=1, mem_is_fetch=1.
  - On mem_ready: ir_we=1, pc_we=1, pc_sel=00, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE
  - One cycle; class taken from instr[6:0].
  - 0110011 R, 0010011 I-ALU, 0000011 LOAD, 0100011 STORE, 1100011 BRANCH, 1101111 JAL.
  - Any other opcode is illegal.
- EXEC
  - R/I-ALU: alu_src_b=00 for R, 01 for I; alu_ctrl from funct3, with sub only when R and funct7[5]=1; go to WB.
  - funct3 map: 000 add/sub, 111 and, 110 or, 100 xor, 010 slt, others add.
  - LOAD/STORE: alu_src_b=01, add; go to MEM.
  - BRANCH: sub on rs1/rs2.
    - Taken = alu_zero XOR funct3[0] (beq/bne).
    - If taken: pc_we=1, pc_sel=01.
    - Go to FETCH.
  - JAL: reg_wr_en=(rd!=0), wb_sel=10, pc_we=1, pc_sel=10; go to FETCH.
- MEM
  - mem_req=1, mem_we=STORE, mem_is_fetch=0, ALU held at add.
  - On mem_ready: STORE goes to FETCH, LOAD goes to WB.
  - Otherwise stay in MEM.
- WB
  - reg_wr_en=(rd!=0); wb_sel=01 for LOAD, 00 otherwise; go to FETCH.
- Handshake
  - Once asserted, mem_req and mem_we/mem_is_fetch stay stable until the mem_ready cycle.
  - mem_ready while mem_req=0 is ignored.
- Wait counter and timeout
  - wait_cnt increments each cycle with mem_req=1 and mem_ready=0.
  - It clears on mem_ready or on leaving FETCH/MEM.
  - When wait_cnt reaches MAX_WAIT (mem_ready still 0): bus_err<=1, state<=HALT.
  - mem_ready on the same cycle the count reaches MAX_WAIT wins: no error.
- HALT: all outputs 0; exits only on reset.
- Latency, with mem_ready=1 immediately: R/I 4 cycles, LOAD 5, STORE 4, BRANCH 3, JAL 3.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined: adds output trap (1 bit). An illegal opcode in DECODE pulses trap=1 for that cycle, and state goes to HALT with bus_err unchanged.
- Undefined: no trap port; an illegal opcode is a NOP (DECODE goes to FETCH, no writes).

Decomposition:
- ctrl_pkg holds:
  - state_t enum (3 bits, encodings above);
  - opcode localparams;
  - ALU_ADD/SUB/AND/OR/XOR/SLT codes;
  - PC_SEL_* and WB_SEL_* codes.
- One sub-module: alu_decoder, purely combinational: (class, funct3, funct7[5]) -> alu_ctrl.

Test Plan:
- Reset: reset high 3 cycles then low with mem_ready=1 -> first cycle after reset: state_o=0, mem_req=1, mem_is_fetch=1, ir_we=1, pc_we=1.
- R-type: instr=0x40B50533 (sub x10,x10,x11) -> EXEC alu_ctrl=0110, alu_src_b=00; WB reg_wr_en=1, wb_sel=00; 4 cycles total.
- LOAD: instr=0x0005A503 (lw x10,0(x11)) with mem_ready low 3 cycles in MEM -> mem_req held 4 cycles, mem_we=0; WB wb_sel=01.
- BRANCH: instr=0x00B50463 (beq): alu_zero=1 -> pc_we=1, pc_sel=01; alu_zero=0 -> pc_we=0; bne variant inverts both.
- Timeout: MAX_WAIT=4, mem_ready=0 in FETCH -> bus_err=1 and state_o=5 after the 4th wait cycle; mem_ready at count 4 -> no error.
- Illegal opcode 0x0000007F and rd=x0 JAL (0x0080006F): with ILLEGAL_TRAP_EN, trap pulse and HALT; without it, no writes and back to FETCH. JAL with rd=0 -> reg_wr_en=0, pc_we=1, pc_sel=10.
